// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   RV32I instruction fetch stage. Pulls one 32-bit instruction as four byte
//   reads over the shared byte-wide memory port, assembles them little-endian
//   and hands {pc, inst} to decode through a one-entry valid/ready register.
//   A branch redirect discards any in-flight fetch and restarts at the target.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   branch_flag_i       redirect request, sampled on the clock edge
//   branch_target_i     redirect address (bits [1:0] forced to 0)
//   mem_req_o           byte read request
//   mem_addr_o          byte address of the request
//   mem_gnt_i           request accepted this cycle
//   mem_rdata_i         read data, one cycle after the grant
//   id_ready_i          decode accepts the output this cycle
//   inst_valid_o        output register holds an instruction
//   inst_o, pc_o        assembled instruction and its address
//
// State     | meaning
// ----------+---------------------------------------------------------------
// S_FETCH   | issuing the four byte requests of the word at fetch_pc
// S_DRAIN   | last byte returning; forward it straight into the output slot
// S_HOLD    | full word parked in asm_buf, waiting for the output slot
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic [7:0]  mem_rdata_i,
    input  logic        id_ready_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [1:0]  r_iss_cnt;
    logic [31:0] r_asm_buf;
    logic        r_pend;
    logic [1:0]  r_pend_idx;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;

    state_t      w_state_nxt;
    logic [31:0] w_fetch_pc_nxt;
    logic [1:0]  w_iss_cnt_nxt;
    logic [31:0] w_asm_buf_nxt;
    logic        w_pend_nxt;
    logic [1:0]  w_pend_idx_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_inst_nxt;
    logic [31:0] w_pc_nxt;

    logic        w_slot_free;
    logic [31:0] w_word;
    logic [31:0] w_target;

    assign w_slot_free = !r_valid || id_ready_i;
    // In DRAIN the last byte is still on the bus, so the word is completed
    // combinationally instead of waiting a cycle for it to land in asm_buf.
    assign w_word      = {mem_rdata_i, r_asm_buf[23:0]};
    assign w_target    = branch_target_i & ~32'h0000_0003;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_iss_cnt_nxt  = r_iss_cnt;
        w_asm_buf_nxt  = r_asm_buf;
        w_pend_nxt     = 1'b0;
        w_pend_idx_nxt = r_pend_idx;
        w_valid_nxt    = r_valid;
        w_inst_nxt     = r_inst;
        w_pc_nxt       = r_pc;

        if (r_pend) begin
            w_asm_buf_nxt[{r_pend_idx, 3'b000} +: 8] = mem_rdata_i;
        end

        if (r_valid && id_ready_i) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            S_FETCH: begin
                if (mem_gnt_i) begin
                    w_pend_nxt     = 1'b1;
                    w_pend_idx_nxt = r_iss_cnt;
                    w_iss_cnt_nxt  = r_iss_cnt + 2'd1;
                    if (r_iss_cnt == 2'd3) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_slot_free) begin
                    w_valid_nxt    = 1'b1;
                    w_inst_nxt     = w_word;
                    w_pc_nxt       = r_fetch_pc;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = S_FETCH;
                end else begin
                    w_asm_buf_nxt  = w_word;
                    w_state_nxt    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_slot_free) begin
                    w_valid_nxt    = 1'b1;
                    w_inst_nxt     = r_asm_buf;
                    w_pc_nxt       = r_fetch_pc;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // Redirect wins over everything above, including a same-cycle accept
        // or a DRAIN/HOLD transfer; a byte granted now will be dropped.
        if (branch_flag_i) begin
            w_valid_nxt    = 1'b0;
            w_iss_cnt_nxt  = 2'd0;
            w_pend_nxt     = 1'b0;
            w_fetch_pc_nxt = w_target;
            w_state_nxt    = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_iss_cnt  <= 2'd0;
            r_asm_buf  <= 32'd0;
            r_pend     <= 1'b0;
            r_pend_idx <= 2'd0;
            r_valid    <= 1'b0;
            r_inst     <= 32'd0;
            r_pc       <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_iss_cnt  <= w_iss_cnt_nxt;
            r_asm_buf  <= w_asm_buf_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_idx <= w_pend_idx_nxt;
            r_valid    <= w_valid_nxt;
            r_inst     <= w_inst_nxt;
            r_pc       <= w_pc_nxt;
        end
    end

    // Outputs show reset values during any rst cycle, so a mid-operation
    // reset silences the memory port and decode interface immediately.
    assign mem_req_o    = !rst && (r_state == S_FETCH);
    assign mem_addr_o   = rst ? RESET_PC : (r_fetch_pc + {30'd0, r_iss_cnt});
    assign inst_valid_o = !rst && r_valid;
    assign inst_o       = rst ? 32'd0 : r_inst;
    assign pc_o         = rst ? 32'd0 : r_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//   Scoreboard bench for inst_fetch. The reference model is the program-order
//   instruction stream: starting at the reset PC or a redirect target, decode
//   must see consecutive words pc, pc+4, ... each equal to the little-endian
//   word in the bench memory. Stimulus refills the expected queue on every
//   reset/redirect; a monitor pops on each accepted handshake.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_rdata_i;
    logic        id_ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int total = 0;
    int bad = 0;
    int n_consumed = 0;
    logic [63:0] sb_q[$];

    inst_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rdata_i     (mem_rdata_i),
        .id_ready_i      (id_ready_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .pc_o            (pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memb(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'd0: return 8'h13;
            32'd1: return 8'h05;
            32'd2: return 8'h10;
            32'd3: return 8'h00;
            default: begin
                h = a * 32'h9E37_79B1;
                h = h ^ (h >> 15);
                return h[23:16];
            end
        endcase
    endfunction

    function automatic logic [31:0] memw(input logic [31:0] pc);
        return {memb(pc + 32'd3), memb(pc + 32'd2), memb(pc + 32'd1), memb(pc)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sb_restart(input logic [31:0] start);
        logic [31:0] p;
        sb_q.delete();
        p = start;
        for (int i = 0; i < 64; i++) begin
            sb_q.push_back({p, memw(p)});
            p = p + 32'd4;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at the start of cycle 0 (first cycle with rst low).
    task automatic apply_reset(input int n);
        next_cycle();
        rst = 1'b1;
        branch_flag_i = 1'b0;
        sb_restart(RESET_PC);
        @(negedge clk);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_valid", inst_valid_o, 1'b0);
        chk("rst_addr", mem_addr_o, RESET_PC);
        repeat (n) next_cycle();
        rst = 1'b0;
    endtask

    // Memory: returns the granted byte exactly one cycle later, garbage otherwise.
    initial begin
        logic        g;
        logic [31:0] a;
        mem_rdata_i = 8'h00;
        forever begin
            @(negedge clk);
            g = mem_req_o && mem_gnt_i && !rst;
            a = mem_addr_o;
            @(posedge clk);
            #1;
            mem_rdata_i = g ? memb(a) : 8'($urandom);
        end
    end

    // Monitor: handshake scoreboard plus hold/stall stability.
    initial begin
        logic        p_ok = 1'b0;
        logic        p_valid, p_ready, p_branch, p_rst, p_req, p_gnt;
        logic [31:0] p_inst, p_pc, p_addr;
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (p_ok && !rst) begin
                if (p_valid && !p_ready && !p_branch && !p_rst) begin
                    chk("hold_valid", inst_valid_o, 1'b1);
                    chk("hold_inst", inst_o, p_inst);
                    chk("hold_pc", pc_o, p_pc);
                end
                if (p_req && !p_gnt && !p_branch && !p_rst) begin
                    chk("stall_req", mem_req_o, 1'b1);
                    chk("stall_addr", mem_addr_o, p_addr);
                end
            end
            if (!rst && inst_valid_o && id_ready_i && !branch_flag_i) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got pc %h with nothing expected", pc_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_pc", pc_o, e[63:32]);
                    chk("sb_inst", inst_o, e[31:0]);
                    n_consumed++;
                end
            end
            p_ok = 1'b1;
            p_valid = inst_valid_o; p_ready = id_ready_i; p_branch = branch_flag_i;
            p_rst = rst; p_req = mem_req_o; p_gnt = mem_gnt_i;
            p_inst = inst_o; p_pc = pc_o; p_addr = mem_addr_o;
        end
    end

    initial begin
        int since;
        rst = 1'b1;
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;
        mem_gnt_i = 1'b0;
        id_ready_i = 1'b0;

        // Reset fetch followed by 12 cycles of backpressure.
        apply_reset(2);
        mem_gnt_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c != 0) next_cycle();
            id_ready_i = (c >= 12);
            @(negedge clk);
            if (c <= 3) begin
                chk("a_addr", mem_addr_o, 32'(c));
                chk("a_req", mem_req_o, 1'b1);
            end
            case (c)
                4: chk("a_drain_req", mem_req_o, 1'b0);
                5: begin
                    chk("a_valid", inst_valid_o, 1'b1);
                    chk("a_inst", inst_o, 32'h0010_0513);
                    chk("a_pc", pc_o, 32'h0);
                    chk("a_next_addr", mem_addr_o, 32'h4);
                end
                11: begin
                    chk("a_hold_req", mem_req_o, 1'b0);
                    chk("a_hold_pc", pc_o, 32'h0);
                    chk("a_hold_inst", inst_o, 32'h0010_0513);
                end
                13: begin
                    chk("a_sw_valid", inst_valid_o, 1'b1);
                    chk("a_sw_pc", pc_o, 32'h4);
                    chk("a_sw_inst", inst_o, memw(32'h4));
                    chk("a_sw_addr", mem_addr_o, 32'h8);
                end
                default: ;
            endcase
        end

        // Grant stall for 3 cycles at byte 2.
        apply_reset(1);
        id_ready_i = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c != 0) next_cycle();
            mem_gnt_i = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 5) chk("b_addr", mem_addr_o, 32'h2);
            case (c)
                7: chk("b_valid_lo", inst_valid_o, 1'b0);
                8: begin
                    chk("b_valid", inst_valid_o, 1'b1);
                    chk("b_inst", inst_o, 32'h0010_0513);
                end
                default: ;
            endcase
        end

        // Redirect during the grant of byte 1.
        apply_reset(1);
        mem_gnt_i = 1'b1;
        id_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            branch_flag_i = (c == 1);
            branch_target_i = 32'h102;
            if (c == 1) sb_restart(32'h100);
            @(negedge clk);
            case (c)
                2: begin
                    chk("c_addr", mem_addr_o, 32'h100);
                    chk("c_req", mem_req_o, 1'b1);
                    chk("c_valid", inst_valid_o, 1'b0);
                end
                7: begin
                    chk("c_valid2", inst_valid_o, 1'b1);
                    chk("c_pc", pc_o, 32'h100);
                    chk("c_inst", inst_o, memw(32'h100));
                end
                default: ;
            endcase
        end
        branch_flag_i = 1'b0;

        // Redirect together with an accept while in DRAIN.
        apply_reset(1);
        for (int c = 0; c < 16; c++) begin
            if (c != 0) next_cycle();
            id_ready_i = (c == 9);
            branch_flag_i = (c == 9);
            branch_target_i = 32'h200;
            if (c == 9) sb_restart(32'h200);
            @(negedge clk);
            case (c)
                9: begin
                    chk("d_valid", inst_valid_o, 1'b1);
                    chk("d_drain", mem_req_o, 1'b0);
                end
                10: begin
                    chk("d_valid_lo", inst_valid_o, 1'b0);
                    chk("d_addr", mem_addr_o, 32'h200);
                end
                15: begin
                    chk("d_pc", pc_o, 32'h200);
                    chk("d_inst", inst_o, memw(32'h200));
                end
                default: ;
            endcase
        end
        branch_flag_i = 1'b0;

        // Reset in the DRAIN cycle.
        apply_reset(1);
        id_ready_i = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c != 0) next_cycle();
            rst = (c == 4);
            if (c == 4) sb_restart(RESET_PC);
            @(negedge clk);
            case (c)
                4: begin
                    chk("e_req", mem_req_o, 1'b0);
                    chk("e_valid", inst_valid_o, 1'b0);
                    chk("e_inst", inst_o, 32'h0);
                    chk("e_pc", pc_o, 32'h0);
                    chk("e_addr", mem_addr_o, RESET_PC);
                end
                5: begin
                    chk("e_restart_addr", mem_addr_o, RESET_PC);
                    chk("e_restart_valid", inst_valid_o, 1'b0);
                end
                10: begin
                    chk("e_pc2", pc_o, RESET_PC);
                    chk("e_inst2", inst_o, 32'h0010_0513);
                end
                default: ;
            endcase
        end

        // PC wrap from the top of the address space.
        apply_reset(1);
        for (int c = 0; c < 12; c++) begin
            if (c != 0) next_cycle();
            branch_flag_i = (c == 0);
            branch_target_i = 32'hFFFF_FFFE;
            if (c == 0) sb_restart(32'hFFFF_FFFC);
            @(negedge clk);
            case (c)
                1:  chk("w_addr", mem_addr_o, 32'hFFFF_FFFC);
                6:  chk("w_pc", pc_o, 32'hFFFF_FFFC);
                11: begin
                    chk("w_pc_wrap", pc_o, 32'h0);
                    chk("w_inst_wrap", inst_o, 32'h0010_0513);
                end
                default: ;
            endcase
        end
        branch_flag_i = 1'b0;

        // Randomized traffic.
        apply_reset(1);
        since = 0;
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            mem_gnt_i = ($urandom_range(0, 99) < 75);
            id_ready_i = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                branch_flag_i = 1'b0;
                sb_restart(RESET_PC);
                since = 0;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 39) == 0 || since >= 150) begin
                    case ($urandom_range(0, 3))
                        0: branch_target_i = $urandom;
                        1: branch_target_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                        2: branch_target_i = 32'($urandom_range(0, 255));
                        default: branch_target_i = 32'h1000 + 32'($urandom_range(0, 4095));
                    endcase
                    branch_flag_i = 1'b1;
                    sb_restart(branch_target_i & ~32'h3);
                    since = 0;
                end else begin
                    branch_flag_i = 1'b0;
                    since++;
                end
            end
        end
        next_cycle();
        rst = 1'b0;
        branch_flag_i = 1'b0;
        @(negedge clk);
        chk("progress", 32'(n_consumed > 150), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the RV32I pipeline. It reads a 32-bit instruction as four byte reads from the shared byte-wide memory port, assembles them little-endian, and presents {pc, inst} to the decode stage through a one-entry valid/ready output register. It also accepts branch redirects from later stages and discards any in-flight fetch when one arrives.

## Interface
- RESET_PC, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- branch_flag_i  in  1  redirect request, sampled on the clock edge.
- branch_target_i  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- mem_req_o  out  1  byte read request.
- mem_addr_o  out  32  byte address of the request.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rdata_i  in  8  read data, valid exactly one cycle after the grant cycle.
- id_ready_i  in  1  decode accepts the output this cycle.
- inst_valid_o  out  1  output register holds an instruction.
- inst_o  out  32  assembled instruction.
- pc_o  out  32  address of inst_o.

## Operation
- Internal state:
  - fetch_pc: 32-bit word address of the instruction being fetched.
  - iss_cnt: 2-bit count of bytes granted.
  - asm_buf: 32-bit assembly buffer.
  - pend, pend_idx: a byte is returning next cycle, and its lane index.
  - fsm: FETCH / DRAIN / HOLD.
- FETCH:
  - mem_req_o=1 and mem_addr_o=fetch_pc+iss_cnt.
  - On each grant, the current index is latched into pend_idx, pend is set, and iss_cnt increments.
  - On the 4th grant (iss_cnt=3), iss_cnt wraps to 0 and the FSM goes to DRAIN.
- Return path: when pend=1, mem_rdata_i is written to asm_buf[8*pend_idx+7 : 8*pend_idx]. Byte 0 is inst[7:0] (little-endian).
- DRAIN: mem_req_o=0. In this cycle byte 3 is on mem_rdata_i. The full word is {mem_rdata_i, asm_buf[23:0]}.
  - Slot free (inst_valid_o=0, or inst_valid_o & id_ready_i): load inst_o=word and pc_o=fetch_pc, keep inst_valid_o=1, set fetch_pc+=4, go to FETCH.
  - Slot not free: store the word in asm_buf and go to HOLD.
- HOLD: mem_req_o=0. Once the slot is free, move asm_buf into the output with pc_o=fetch_pc, set fetch_pc+=4, go to FETCH.
- Output handshake: the entry is consumed when inst_valid_o & id_ready_i. inst_o and pc_o are stable while inst_valid_o=1 and id_ready_i=0. Consumption with no new word ready clears inst_valid_o.
- mem_gnt_i low in FETCH: mem_req_o and mem_addr_o are held; no progress.
- Redirect (branch_flag_i=1, any state):
  - Next cycle: inst_valid_o=0, iss_cnt=0, fsm=FETCH, fetch_pc=target & ~3.
  - pend is cleared, so a byte granted in the redirect cycle or returning in the next cycle is dropped.
  - Redirect overrides a DRAIN/HOLD transfer and an id_ready_i accept in the same cycle.
- fetch_pc+4 wraps modulo 2^32.

## Timing
- Reset values, for any cycle with rst=1, mid-operation included:
  - inst_valid_o=0, inst_o=0, pc_o=0, mem_req_o=0.
  - mem_addr_o=RESET_PC, fetch_pc=RESET_PC, iss_cnt=0, pend=0, fsm=FETCH.
  - rst has priority over branch_flag_i.
- mem_req_o and mem_addr_o are driven from registered state only. There is no combinational path from mem_gnt_i or branch_flag_i.
- With continuous grants (cycle 0 = first cycle after rst falls):
  - Requests in cycles 0-3.
  - Bytes return in cycles 1-4.
  - inst_valid_o=1 from cycle 5.
  - Next requests start in cycle 5.
- Steady-state throughput with id_ready_i=1: one instruction per 5 cycles. Each grant-stall cycle adds 1.
- Redirect latency: requests to the target start the cycle after branch_flag_i.

## Test plan
- Reset fetch: memory at 0x0 holds 13 05 10 00, always granted.
  - mem_addr_o reads 0,1,2,3 in cycles 0-3.
  - inst_o=0x00100513, pc_o=0, inst_valid_o=1 in cycle 5.
  - Next request is at address 4.
- Backpressure: id_ready_i=0 for 10 cycles.
  - First word is held stable.
  - Second word reaches HOLD with mem_req_o=0.
  - On id_ready_i=1, the output switches to pc 4 the next cycle with no lost or duplicated word.
- Grant stall: mem_gnt_i=0 at byte 2 for 3 cycles.
  - mem_addr_o holds 0x2.
  - The word is still assembled correctly.
  - inst_valid_o rises 3 cycles late.
- Mid-fetch redirect: branch_flag_i with target 0x102 during the grant of byte 1.
  - Byte 1 data is dropped.
  - Next cycle mem_addr_o=0x100.
  - The delivered inst uses only bytes 0x100-0x103, with pc_o=0x100.
- Redirect and accept in the same cycle: inst_valid_o=1, id_ready_i=1, branch_flag_i=1 while in DRAIN.
  - inst_valid_o=0 next cycle.
  - The drained word is discarded.
- Reset mid-DRAIN: rst for 1 cycle.
  - All outputs reach their reset values.
  - Fetch restarts at RESET_PC.
  - The returning byte is ignored.
